nor_stream_reducer: RTL

- Parametrised, sequential successor to the team's 2-input NOR gate.
- Accepts a framed stream of WIDTH-bit operands over a valid/ready handshake and reduces each frame to one bitwise NOR (or OR) result.
- Presents the result, beat count and overflow flag on a registered valid/ready output.
- Sits between operand producers and downstream logic that needs an N-input NOR of arbitrary, runtime-variable arity.

---
 rtl/nor_stream_reducer.sv | 110 +++++++++++
 1 files changed

// File: rtl/nor_stream_reducer.sv
// Reduces a framed valid/ready operand stream to one bitwise NOR (or OR) per frame,
// with a saturating beat count and an overflow flag on a registered result port.
module nor_stream_reducer #(
    parameter int WIDTH   = 8,
    parameter int MAX_OPS = 16,
    parameter int INVERT  = 1,
    localparam int CW     = $clog2(MAX_OPS + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [WIDTH-1:0] s_data,
    input  logic             s_last,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_data,
    output logic [CW-1:0]    m_count,
    output logic             m_overflow
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t             state, state_nxt;
    logic [WIDTH-1:0]   acc, acc_nxt;
    logic [CW-1:0]      cnt, cnt_nxt;
    logic               ovf, ovf_nxt;
    logic               beat;
    logic               frame_end;

    function automatic logic [WIDTH-1:0] result_sel(input logic [WIDTH-1:0] a);
        return (INVERT != 0) ? ~a : a;
    endfunction

    // Ready comes from registered state only, so it never loops through s_valid or m_ready.
    assign s_ready = rst_n && (state != HOLD);
    assign beat    = s_valid && s_ready;

    always_comb begin
        state_nxt = state;
        acc_nxt   = acc;
        cnt_nxt   = cnt;
        ovf_nxt   = ovf;
        frame_end = 1'b0;
        case (state)
            IDLE: begin
                if (beat) begin
                    acc_nxt   = s_data;
                    cnt_nxt   = CW'(1);
                    ovf_nxt   = 1'b0;
                    frame_end = s_last;
                    state_nxt = s_last ? HOLD : ACCUM;
                end
            end
            ACCUM: begin
                if (beat) begin
                    acc_nxt = acc | s_data;
                    // Past saturation the data still folds in; only the count stops.
                    if (cnt == CW'(MAX_OPS)) begin
                        ovf_nxt = 1'b1;
                    end else begin
                        cnt_nxt = cnt + CW'(1);
                    end
                    if (s_last) begin
                        frame_end = 1'b1;
                        state_nxt = HOLD;
                    end
                end
            end
            HOLD: begin
                if (m_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            acc        <= '0;
            cnt        <= '0;
            ovf        <= 1'b0;
            m_valid    <= 1'b0;
            m_data     <= '0;
            m_count    <= '0;
            m_overflow <= 1'b0;
        end else begin
            state <= state_nxt;
            acc   <= acc_nxt;
            cnt   <= cnt_nxt;
            ovf   <= ovf_nxt;
            // Result registers are only rewritten at a frame end and hold otherwise.
            if (frame_end) begin
                m_valid    <= 1'b1;
                m_data     <= result_sel(acc_nxt);
                m_count    <= cnt_nxt;
                m_overflow <= ovf_nxt;
            end else if (m_valid && m_ready) begin
                m_valid <= 1'b0;
            end
        end
    end

endmodule
